// File: rtl/lcd_seq.sv
// LCD panel sequencer: pulses the panel reset, plays the init ROM through lcd_spi,
// then forwards a user byte stream (with D/C flag) onto the same serializer.
//
// state          | meaning
// ST_RST_ASSERT  | panel reset held low for RST_CYCLES clocks
// ST_RST_WAIT    | panel reset released, waiting RST_WAIT clocks
// ST_FETCH       | synchronous ROM read of addr (addr==INIT_LEN ends the script)
// ST_DECODE      | dispatch ROM word: byte, delay or end marker
// ST_SEND        | byte presented to lcd_spi until done (ROM or user source)
// ST_DELAY       | script delay, byte*DELAY_UNIT clocks
// ST_IDLE        | init finished, accepting user bytes
module lcd_seq #(
    parameter int                     RST_CYCLES = 500_000,
    parameter int                     RST_WAIT   = 6_000_000,
    parameter int                     DELAY_UNIT = 50_000,
    parameter int                     INIT_LEN   = 64,
    parameter logic [INIT_LEN*10-1:0] INIT_ROM   = {INIT_LEN{10'h300}}
) (
    input  logic       clock,
    input  logic       reset_n,
    output logic [7:0] spi_data_o,
    output logic       spi_push_o,
    input  logic       spi_done_i,
    output logic       lcd_dc_o,
    output logic       lcd_cs_n_o,
    output logic       lcd_rst_n_o,
    output logic       init_done_o,
    input  logic [7:0] s_data_i,
    input  logic       s_dc_i,
    input  logic       s_valid_i,
    output logic       s_ready_o
);

    localparam int AW      = $clog2(INIT_LEN + 1);
    localparam int ROM_D   = 2 ** AW;
    localparam int DLY_MAX = 255 * DELAY_UNIT;
    localparam int RST_MAX = (RST_CYCLES > RST_WAIT) ? RST_CYCLES : RST_WAIT;
    localparam int CW      = $clog2(((DLY_MAX > RST_MAX) ? DLY_MAX : RST_MAX) + 1);

    typedef enum logic [2:0] {
        ST_RST_ASSERT,
        ST_RST_WAIT,
        ST_FETCH,
        ST_DECODE,
        ST_SEND,
        ST_DELAY,
        ST_IDLE
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [AW-1:0]   addr;
    logic [9:0]      rom_q;
    logic            from_rom;
    logic [9:0]      rom [ROM_D];

    // Addresses past the script read as end markers so the ROM index is full width.
    for (genvar i = 0; i < ROM_D; i++) begin : g_rom
        if (i < INIT_LEN) begin : g_word
            assign rom[i] = INIT_ROM[i*10 +: 10];
        end else begin : g_pad
            assign rom[i] = 10'h300;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_RST_ASSERT;
            cnt         <= CW'(RST_CYCLES - 1);
            addr        <= '0;
            rom_q       <= '0;
            from_rom    <= 1'b0;
            spi_data_o  <= 8'h00;
            spi_push_o  <= 1'b0;
            lcd_dc_o    <= 1'b0;
            lcd_cs_n_o  <= 1'b1;
            lcd_rst_n_o <= 1'b0;
            init_done_o <= 1'b0;
            s_ready_o   <= 1'b0;
        end else begin
            case (state)
                ST_RST_ASSERT: begin
                    if (cnt == '0) begin
                        state       <= ST_RST_WAIT;
                        cnt         <= CW'(RST_WAIT - 1);
                        lcd_rst_n_o <= 1'b1;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                ST_RST_WAIT: begin
                    if (cnt == '0) begin
                        state <= ST_FETCH;
                        addr  <= '0;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                ST_FETCH: begin
                    if (addr == AW'(INIT_LEN)) begin
                        state       <= ST_IDLE;
                        init_done_o <= 1'b1;
                        s_ready_o   <= 1'b1;
                    end else begin
                        rom_q <= rom[addr];
                        state <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    case (rom_q[9:8])
                        2'b00, 2'b01: begin
                            spi_data_o <= rom_q[7:0];
                            lcd_dc_o   <= rom_q[8];
                            spi_push_o <= 1'b1;
                            lcd_cs_n_o <= 1'b0;
                            from_rom   <= 1'b1;
                            state      <= ST_SEND;
                        end
                        2'b10: begin
                            if (rom_q[7:0] == 8'h00) begin
                                addr  <= addr + AW'(1);
                                state <= ST_FETCH;
                            end else begin
                                cnt   <= CW'(rom_q[7:0]) * CW'(DELAY_UNIT) - CW'(1);
                                state <= ST_DELAY;
                            end
                        end
                        default: begin
                            state       <= ST_IDLE;
                            init_done_o <= 1'b1;
                            s_ready_o   <= 1'b1;
                        end
                    endcase
                end
                ST_SEND: begin
                    // A user byte enters with push low; done is only honoured once push is up.
                    if (!spi_push_o) begin
                        spi_push_o <= 1'b1;
                        lcd_cs_n_o <= 1'b0;
                    end else if (spi_done_i) begin
                        spi_push_o <= 1'b0;
                        lcd_cs_n_o <= 1'b1;
                        if (from_rom) begin
                            addr  <= addr + AW'(1);
                            state <= ST_FETCH;
                        end else begin
                            state     <= ST_IDLE;
                            s_ready_o <= 1'b1;
                        end
                    end
                end
                ST_DELAY: begin
                    if (cnt == '0) begin
                        addr  <= addr + AW'(1);
                        state <= ST_FETCH;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                ST_IDLE: begin
                    if (s_valid_i && s_ready_o) begin
                        spi_data_o <= s_data_i;
                        lcd_dc_o   <= s_dc_i;
                        s_ready_o  <= 1'b0;
                        from_rom   <= 1'b0;
                        state      <= ST_SEND;
                    end
                end
                default: state <= ST_RST_ASSERT;
            endcase
        end
    end

endmodule
